// File: rtl/reg_bus_master.sv
// ---------------------------------------------------------------------------
// reg_bus_master
//   Single-outstanding initiator for the narrow register bus (wr/addr/din out,
//   dout in). A request taken on the valid/ready request port becomes exactly
//   one bus cycle. A read then waits RD_LAT cycles, captures the slave's dout
//   and returns it on the valid/ready response port. A write returns a
//   response with zero data. Completed writes and reads are counted at the
//   response handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_wr, req_addr, req_wdata payload
//   rsp_valid/rsp_ready   response handshake; rsp_wr, rsp_rdata payload
//   bus_wr/addr/din       registered drive to the slave
//   bus_dout              slave read data
//   busy                  high whenever the FSM is not idle
//   wr_cnt, rd_cnt        completed-transaction counters, wrap at 2^CNT_W
// ---------------------------------------------------------------------------
module reg_bus_master #(
    parameter int                 ADDR_W    = 1,
    parameter int                 RD_LAT    = 1,
    parameter logic [ADDR_W-1:0]  IDLE_ADDR = ADDR_W'(1),
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic [7:0]        rsp_rdata,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_din,
    input  logic [7:0]        bus_dout,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    localparam int LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state;
    logic               txn_wr;    // direction of the transaction in flight
    logic [LAT_W-1:0]   lat_cnt;   // read-latency cycles still to wait

    // NOTE: req_ready is a plain continuous assignment of registered state,
    // so it can never infer a latch; it is forced low while reset is held.
    assign req_ready = (state == ST_IDLE) && rst_n;
    assign busy      = (state != ST_IDLE);

    // NOTE: every register below is written with non-blocking assignments so
    // all of them update together at the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            txn_wr    <= 1'b0;
            lat_cnt   <= '0;
            bus_wr    <= 1'b0;
            bus_addr  <= IDLE_ADDR;
            bus_din   <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= 8'h00;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The bus registers double as the request latch: they
                    // present the request to the slave during DRIVE.
                    if (req_valid) begin
                        txn_wr   <= req_wr;
                        bus_wr   <= req_wr;
                        bus_addr <= req_addr;
                        bus_din  <= req_wdata;
                        state    <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    // Back to the no-op address immediately: the slave has no
                    // enable, so wr=0 on a real address would be another read.
                    // bus_din is left alone on purpose.
                    bus_wr   <= 1'b0;
                    bus_addr <= IDLE_ADDR;
                    if (txn_wr) begin
                        rsp_valid <= 1'b1;
                        rsp_wr    <= 1'b1;
                        rsp_rdata <= 8'h00;
                        state     <= ST_RESP;
                    end else begin
                        lat_cnt <= LAT_W'(RD_LAT);
                        state   <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    // lat_cnt==1 marks the RD_LAT-th cycle after DRIVE; dout is
                    // valid on the edge that ends it.
                    if (lat_cnt == LAT_W'(1)) begin
                        rsp_valid <= 1'b1;
                        rsp_wr    <= 1'b0;
                        rsp_rdata <= bus_dout;
                        state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_wr) wr_cnt <= wr_cnt + 1'b1;
                        else        rd_cnt <= rd_cnt + 1'b1;
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_master
//   Drives directed transactions into reg_bus_master connected to a small
//   behavioural register slave (addr0 = one 8-bit register, addr1 = no-op).
//   A transaction-level model predicts, for every cycle, what each output of
//   the master must be; directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_reg_bus_master;

    localparam int                ADDR_W    = 1;
    localparam int                RD_LAT    = 1;
    localparam int                CNT_W     = 3;   // small so wrap is reachable
    localparam logic [ADDR_W-1:0] IDLE_ADDR = 1'b1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              rsp_valid, rsp_ready, rsp_wr;
    logic [7:0]        rsp_rdata;
    logic              bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_din, bus_dout;
    logic              busy;
    logic [CNT_W-1:0]  wr_cnt, rd_cnt;

    reg_bus_master #(
        .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .IDLE_ADDR(IDLE_ADDR), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata),
        .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_din(bus_din),
        .bus_dout(bus_dout),
        .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: read data appears one cycle after a read cycle; any other cycle
    // leaves a marker value on dout so a mistimed capture is visible.
    logic [7:0] slv_reg;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slv_reg  <= 8'h00;
            bus_dout <= 8'h00;
        end else begin
            if (bus_wr && bus_addr == '0) slv_reg <= bus_din;
            bus_dout <= (!bus_wr && bus_addr == '0) ? slv_reg : 8'hEE;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic              m_active;
    int                m_drive_at, m_rsp_at;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_wdata, m_rdata, m_mem0, m_last_din;
    logic [CNT_W-1:0]  m_wr_n, m_rd_n;
    logic              m_drv, m_rsp;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active   = 1'b0;
            m_drive_at = -1;
            m_rsp_at   = -1;
            m_wr       = 1'b0;
            m_addr     = '0;
            m_wdata    = 8'h00;
            m_rdata    = 8'h00;
            m_mem0     = 8'h00;
            m_last_din = 8'h00;
            m_wr_n     = '0;
            m_rd_n     = '0;
        end else begin
            m_drv = m_active && (cyc == m_drive_at);
            m_rsp = m_active && (cyc >= m_rsp_at);
            check("busy",      busy,      m_active);
            check("req_ready", req_ready, !m_active);
            check("bus_wr",    bus_wr,    m_drv ? m_wr : 1'b0);
            check("bus_addr",  bus_addr,  m_drv ? m_addr : IDLE_ADDR);
            check("bus_din",   bus_din,   m_drv ? m_wdata : m_last_din);
            check("rsp_valid", rsp_valid, m_rsp);
            if (m_rsp) begin
                check("rsp_wr",    rsp_wr,    m_wr);
                check("rsp_rdata", rsp_rdata, m_wr ? 8'h00 : m_rdata);
            end
            check("wr_cnt", wr_cnt, m_wr_n);
            check("rd_cnt", rd_cnt, m_rd_n);

            // advance to the next cycle
            if (m_drv) m_last_din = m_wdata;
            if (m_active) begin
                if (m_rsp && rsp_ready) begin
                    m_active = 1'b0;
                    if (m_wr) m_wr_n = m_wr_n + 1'b1;
                    else      m_rd_n = m_rd_n + 1'b1;
                end
            end else if (req_valid) begin
                m_active   = 1'b1;
                m_wr       = req_wr;
                m_addr     = req_addr;
                m_wdata    = req_wdata;
                m_drive_at = cyc + 1;
                m_rsp_at   = req_wr ? cyc + 2 : cyc + 2 + RD_LAT;
                m_rdata    = m_mem0;
                if (req_wr && req_addr == '0) m_mem0 = req_wdata;
            end
        end
    end

    // ---------------- drivers (inputs change at posedge + 1) ----------------
    task automatic wait_accept(output int h);
        h = -1;
        for (int n = 0; n < 20 && h < 0; n++) begin
            @(negedge clk);
            if (req_ready) h = cyc;
        end
        check("req_accept", (h >= 0), 1);
    endtask

    task automatic txn(input logic wr, input logic [ADDR_W-1:0] addr, input logic [7:0] wdata,
                       input int hold, output logic [7:0] rdata, output int lat);
        int h, r;
        rdata = 8'h00;
        lat   = -1;
        req_wr = wr; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        rsp_ready = (hold == 0);
        wait_accept(h);
        @(posedge clk); #1 req_valid = 1'b0;
        if (h < 0) return;
        r = -1;
        for (int n = 0; n < 20 && r < 0; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r = cyc;
                rdata = rsp_rdata;
            end
        end
        check("rsp_arrive", (r >= 0), 1);
        if (r < 0) begin
            rsp_ready = 1'b0;
            return;
        end
        lat = r - h;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    logic [7:0] rd;
    int         lat, h;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = 8'h00; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_bus_wr",    bus_wr,    0);
        check("rst_bus_addr",  bus_addr,  1);
        check("rst_bus_din",   bus_din,   8'h00);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_wr_cnt",    wr_cnt,    0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: read after reset
        txn(1'b0, 1'b0, 8'h00, 0, rd, lat);
        check("t1_rdata", rd, 8'h00);
        check("t1_lat",   lat, 3);
        check("t1_rd_cnt", rd_cnt, 1);

        // 2: write then read back
        txn(1'b1, 1'b0, 8'hA5, 0, rd, lat);
        check("t2_wr_lat", lat, 2);
        txn(1'b0, 1'b0, 8'h00, 0, rd, lat);
        check("t2_rdata", rd, 8'hA5);
        check("t2_wr_cnt", wr_cnt, 1);
        check("t2_rd_cnt", rd_cnt, 2);

        // 3: addr1 write must not disturb addr0
        txn(1'b1, 1'b0, 8'h11, 0, rd, lat);
        txn(1'b1, 1'b1, 8'h3C, 0, rd, lat);
        txn(1'b0, 1'b0, 8'h00, 0, rd, lat);
        check("t3_rdata", rd, 8'h11);
        check("t3_wr_cnt", wr_cnt, 3);

        // 4: response back-pressure for 5 cycles
        txn(1'b1, 1'b0, 8'h5A, 0, rd, lat);
        txn(1'b0, 1'b0, 8'h00, 5, rd, lat);
        check("t4_rdata", rd, 8'h5A);
        check("t4_lat",   lat, 3);
        check("t4_rd_cnt", rd_cnt, 4);

        // 5: reset while waiting on read data
        req_wr = 1'b0; req_addr = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
        wait_accept(h);
        @(posedge clk); #1 req_valid = 1'b0;   // DRIVE
        @(posedge clk); #1;                    // WAIT
        check("t5_busy_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_bus_wr",    bus_wr,    0);
        check("t5_bus_addr",  bus_addr,  1);
        check("t5_wr_cnt",    wr_cnt,    0);
        check("t5_rd_cnt",    rd_cnt,    0);
        check("t5_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 8'h00, 0, rd, lat);
        check("t5_rdata", rd, 8'h00);
        check("t5_rd_cnt_after", rd_cnt, 1);

        // counter wrap: 9 writes on a 3-bit counter
        for (int i = 0; i < 9; i++) txn(1'b1, 1'b0, 8'(8'h10 + i), 0, rd, lat);
        check("wrap_wr_cnt", wr_cnt, 1);
        txn(1'b0, 1'b0, 8'h00, 0, rd, lat);
        check("wrap_rdata", rd, 8'h18);
        check("wrap_rd_cnt", rd_cnt, 2);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
